// File: rtl/conv_pe_sequencer.sv
// Tile sequencer for the PE convolution array: streams KSIZE taps per tile, frames each tile
// with pe_en/pe_finish, and buffers each tile's OFM onto a valid/ready output stream.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | accepting KSIZE taps onto the pe bus
// FINISH | pe_finish pulse; held while the OFM register is full and not draining
// WAIT   | waiting for the array's pe_valid
// DRAIN  | last OFM beat waiting for its downstream handshake
module conv_pe_sequencer #(
  parameter int NUM_PE    = 256,
  parameter int DATA_W    = 8,
  parameter int KSIZE     = 27,
  parameter int NUM_TILES = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       tap_valid,
  output logic                       tap_ready,
  input  logic [NUM_PE*DATA_W-1:0]   tap_ifm,
  input  logic [DATA_W-1:0]          tap_wgt,
  output logic [NUM_PE*DATA_W-1:0]   pe_ifm,
  output logic [DATA_W-1:0]          pe_weight,
  output logic [NUM_PE-1:0]          pe_en,
  output logic [NUM_PE-1:0]          pe_finish,
  input  logic [NUM_PE*DATA_W-1:0]   pe_ofm,
  input  logic                       pe_valid,
  output logic                       ofm_valid,
  input  logic                       ofm_ready,
  output logic [NUM_PE*DATA_W-1:0]   ofm_data
);

  localparam int TAP_W  = $clog2(KSIZE + 1);
  localparam int TILE_W = $clog2(NUM_TILES + 1);

  typedef enum logic [2:0] {IDLE, STREAM, FINISH, WAIT, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [TAP_W-1:0]  tap_cnt;
  logic [TILE_W-1:0] tile_cnt;
  logic              tap_hs, ofm_hs, ofm_hold, capture, last_tile;

  assign busy      = (state != IDLE);
  assign tap_ready = (state == STREAM) && (tap_cnt < TAP_W'(KSIZE));
  assign tap_hs    = tap_valid && tap_ready;
  assign ofm_hs    = ofm_valid && ofm_ready;
  // A full register that is not being drained this cycle cannot take another result.
  assign ofm_hold  = ofm_valid && !ofm_ready;
  assign capture   = (state == WAIT) && pe_valid;
  assign last_tile = (tile_cnt == TILE_W'(NUM_TILES - 1));
  assign pe_finish = {NUM_PE{(state == FINISH) && !ofm_hold}};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !done) state_nxt = STREAM;
      STREAM:  if (tap_cnt == TAP_W'(KSIZE)) state_nxt = FINISH;
      FINISH:  if (!ofm_hold) state_nxt = WAIT;
      WAIT:    if (pe_valid) state_nxt = last_tile ? DRAIN : STREAM;
      DRAIN:   if (ofm_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tap_cnt   <= '0;
      tile_cnt  <= '0;
      pe_ifm    <= '0;
      pe_weight <= '0;
      pe_en     <= '0;
      ofm_valid <= 1'b0;
      ofm_data  <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pe_ifm    <= tap_hs ? tap_ifm : '0;
      pe_weight <= tap_hs ? tap_wgt : '0;
      pe_en     <= {NUM_PE{tap_hs && (tap_cnt == '0)}};
      done      <= (state == DRAIN) && ofm_hs;

      if (tap_hs)
        tap_cnt <= tap_cnt + 1'b1;
      else if (state == IDLE || ((state == FINISH) && !ofm_hold))
        tap_cnt <= '0;

      if (state == IDLE)
        tile_cnt <= '0;
      else if (capture && !last_tile)
        tile_cnt <= tile_cnt + 1'b1;

      // A capture in the same cycle as a handshake replaces the departing beat.
      if (capture) begin
        ofm_valid <= 1'b1;
        ofm_data  <= pe_ofm;
      end else if (ofm_hs) begin
        ofm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Randomized bench for conv_pe_sequencer: a tile-level reference model predicts every output
// each cycle, plus literal per-run tallies (pulse counts, tile framing, reset behaviour).
module tb_conv_pe_sequencer;
  localparam int NP = 256;
  localparam int DW = 8;
  localparam int K  = 27;
  localparam int NT = 12;
  localparam int VW = NP * DW;

  logic          clk = 1'b0;
  logic          reset, start, tap_valid, pe_valid, ofm_ready;
  logic          busy, done, tap_ready, ofm_valid;
  logic [VW-1:0] tap_ifm, pe_ifm, pe_ofm, ofm_data;
  logic [DW-1:0] tap_wgt, pe_weight;
  logic [NP-1:0] pe_en, pe_finish;

  always #5 clk = ~clk;

  conv_pe_sequencer #(.NUM_PE(NP), .DATA_W(DW), .KSIZE(K), .NUM_TILES(NT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .tap_valid(tap_valid), .tap_ready(tap_ready), .tap_ifm(tap_ifm), .tap_wgt(tap_wgt),
    .pe_ifm(pe_ifm), .pe_weight(pe_weight), .pe_en(pe_en), .pe_finish(pe_finish),
    .pe_ofm(pe_ofm), .pe_valid(pe_valid),
    .ofm_valid(ofm_valid), .ofm_ready(ofm_ready), .ofm_data(ofm_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      int lane = 0;
      for (int i = NP - 1; i >= 0; i--)
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) lane = i;
      $display("FAIL %s: lane %0d got %0h expected %0h", name, lane,
               act[lane*DW +: DW], exp[lane*DW +: DW]);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: a run is NT tiles; a tile is K accepted taps, then a finish pulse,
  // then the array result; results queue up for the output stream.
  bit            m_run, m_fin, m_wait, m_drain, m_en, m_done;
  int            m_tile, m_taps;
  logic [VW-1:0] m_ifm;
  logic [DW-1:0] m_wgt;
  logic [VW-1:0] ofm_q[$];

  int            cyc = 0, n_en, n_fin, n_ofm, n_done, en_cyc;
  int            gaps[$];
  logic [DW-1:0] prev_w = '0;
  bit            det_mode;

  always @(negedge clk) begin : cmp
    bit            streaming, e_tr, e_full, e_fin, hs, pop, cap, nxt_en, nxt_done;
    logic [VW-1:0] nxt_ifm;
    logic [DW-1:0] nxt_wgt;
    cyc++;
    if (reset) begin
      m_run = 0; m_fin = 0; m_wait = 0; m_drain = 0; m_en = 0; m_done = 0;
      m_tile = 0; m_taps = 0; m_ifm = '0; m_wgt = '0;
      ofm_q.delete();
    end
    streaming = m_run && !m_fin && !m_wait && !m_drain;
    e_tr      = streaming && (m_taps < K);
    e_full    = (ofm_q.size() > 0);
    e_fin     = m_fin && !(e_full && !ofm_ready);

    check("busy", busy, m_run);
    check("done", done, m_done);
    check("tap_ready", tap_ready, e_tr);
    check("pe_en_ones", $countones(pe_en), m_en ? NP : 0);
    check("pe_finish_ones", $countones(pe_finish), e_fin ? NP : 0);
    check_vec("pe_ifm", pe_ifm, m_ifm);
    check("pe_weight", pe_weight, m_wgt);
    check("ofm_valid", ofm_valid, e_full);
    if (e_full) check_vec("ofm_data", ofm_data, ofm_q[0]);

    if (!reset) begin
      if (pe_en[0]) begin
        n_en++;
        en_cyc = cyc;
        if (det_mode) check("en_first_weight", pe_weight, 1);
      end
      if (pe_finish[0]) begin
        n_fin++;
        gaps.push_back(cyc - en_cyc);
        if (det_mode) check("finish_after_last_tap", prev_w, K);
      end
      if (ofm_valid && ofm_ready) n_ofm++;
      if (done) n_done++;

      hs       = tap_valid && e_tr;
      pop      = e_full && ofm_ready;
      cap      = 0;
      nxt_done = 0;
      nxt_en   = hs && (m_taps == 0);
      nxt_ifm  = hs ? tap_ifm : '0;
      nxt_wgt  = hs ? tap_wgt : '0;
      if (!m_run) begin
        if (start && !m_done) begin m_run = 1; m_tile = 0; m_taps = 0; end
      end else if (streaming) begin
        if (hs) m_taps++;
        else if (m_taps == K) m_fin = 1;
      end else if (m_fin) begin
        if (e_fin) begin m_fin = 0; m_wait = 1; m_taps = 0; end
      end else if (m_wait) begin
        if (pe_valid) begin
          cap = 1; m_wait = 0; m_tile++;
          if (m_tile == NT) m_drain = 1;
        end
      end else if (m_drain && pop) begin
        m_drain = 0; m_run = 0; nxt_done = 1;
      end
      if (pop) void'(ofm_q.pop_front());
      if (cap) ofm_q.push_back(pe_ofm);
      m_en = nxt_en; m_ifm = nxt_ifm; m_wgt = nxt_wgt; m_done = nxt_done;
    end
    prev_w = pe_weight;
  end

  // Stimulus state
  int tap_idx = 0, pv_delay = 0, pe_lat = 3, hold_left = -1, ofm_mode = 0, tk_ofm = 0;
  bit dropped = 0, drop_mode = 0, rand_mode = 0, spurious_pv = 0, start_req = 0, start_on_done = 0;

  task automatic tick();
    logic s_hs, s_fin, s_ov, s_ohs;
    @(negedge clk);
    s_hs  = tap_valid && tap_ready;
    s_fin = pe_finish[0];
    s_ov  = ofm_valid;
    s_ohs = ofm_valid && ofm_ready;
    @(posedge clk);
    #2;
    start = start_req;
    start_req = 0;
    if (reset) begin
      tap_idx = 0; dropped = 0; pv_delay = 0; tk_ofm = 0;
      s_hs = 0; s_fin = 0; s_ohs = 0;
    end
    if (s_ohs) begin
      tk_ofm++;
      if (start_on_done && tk_ofm == NT) start = 1;
    end
    if (s_hs) begin tap_idx = (tap_idx + 1) % K; dropped = 0; end

    pe_valid = spurious_pv;
    spurious_pv = 0;
    if (s_fin) begin
      if (rand_mode) pe_lat = $urandom_range(1, 6);
      pv_delay = pe_lat;
    end
    if (pv_delay > 0) begin
      pv_delay--;
      if (pv_delay == 0) begin pe_valid = 1; pe_ofm = rand_vec(); end
    end
    if (rand_mode && $urandom_range(0, 19) == 0) pe_valid = 1;

    if (rand_mode) tap_valid = ($urandom_range(0, 3) != 0);
    else if (drop_mode && (tap_idx == 4 || tap_idx == 5) && !dropped) begin
      tap_valid = 0; dropped = 1;
    end else tap_valid = 1;

    if (det_mode) begin
      tap_wgt = DW'(tap_idx + 1);
      for (int i = 0; i < NP; i++) tap_ifm[i*DW +: DW] = DW'(tap_idx);
    end else begin
      tap_wgt = DW'($urandom());
      tap_ifm = rand_vec();
    end

    case (ofm_mode)
      0: ofm_ready = 1;
      1: begin
        if (hold_left == -1 && s_ov) hold_left = 100;
        if (hold_left > 0) hold_left--;
        ofm_ready = (hold_left == 0);
      end
      default: ofm_ready = $urandom_range(0, 1);
    endcase
  endtask

  task automatic clear_tallies();
    n_en = 0; n_fin = 0; n_ofm = 0; n_done = 0; tk_ofm = 0;
    gaps.delete();
  endtask

  task automatic run(input string name, input int exp_gap, input bit mid_start);
    int budget = 0;
    clear_tallies();
    start_req = 1;
    tick();
    while (n_done == 0 && budget < 4000) begin
      if (mid_start && budget == 50) start_req = 1;
      tick();
      budget++;
    end
    check({name, "_completes"}, (n_done != 0), 1);
    repeat (5) tick();
    check({name, "_pe_en_count"}, n_en, NT);
    check({name, "_finish_count"}, n_fin, NT);
    check({name, "_ofm_beats"}, n_ofm, NT);
    check({name, "_done_count"}, n_done, 1);
    check({name, "_idle_after"}, busy, 0);
    if (exp_gap >= 0) begin
      int ok = 0;
      foreach (gaps[i]) if (gaps[i] == exp_gap) ok++;
      check({name, "_tile_framing"}, ok, NT);
    end
  endtask

  initial begin
    int budget;
    reset = 0; start = 0; tap_valid = 0; pe_valid = 0; ofm_ready = 1;
    tap_ifm = '0; tap_wgt = '0; pe_ofm = '0;
    det_mode = 1;
    #1 reset = 1;
    repeat (3) tick();
    reset = 0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_tap_ready", tap_ready, 0);
    check("reset_ofm_valid", ofm_valid, 0);
    check("reset_pe_en", $countones(pe_en), 0);
    check("reset_pe_finish", $countones(pe_finish), 0);

    // Steady stream; pe_en lands on the first tap, pe_finish 27 cycles later; start on done ignored.
    start_on_done = 1;
    run("basic", 27, 0);
    start_on_done = 0;

    // Two bubbles inside every tile stretch the framing by two cycles.
    drop_mode = 1;
    run("bubbles", 29, 0);
    drop_mode = 0;

    // Downstream stalls after tile 0; tile 1's finish waits for the OFM register to drain.
    det_mode = 0; ofm_mode = 1; hold_left = -1;
    run("ofm_hold", -1, 0);
    check("hold_delays_finish", (gaps.size() > 1) && (gaps[1] >= 95), 1);
    ofm_mode = 0;

    // Stray pe_valid while idle, and a start while busy, must both be ignored.
    spurious_pv = 1;
    tick();
    tick();
    check("idle_pe_valid_ignored", ofm_valid, 0);
    check("idle_stays_idle", busy, 0);
    run("mid_start", 27, 1);

    // Abort in tile 3 at about tap 10.
    clear_tallies();
    start_req = 1;
    tick();
    budget = 0;
    while (n_en < 4 && budget < 1000) begin tick(); budget++; end
    check("abort_reached_tile3", (n_en >= 4), 1);
    repeat (9) tick();
    reset = 1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_tap_ready", tap_ready, 0);
    check("abort_pe_ifm", $countones(pe_ifm), 0);
    check("abort_pe_weight", pe_weight, 0);
    check("abort_pe_en", $countones(pe_en), 0);
    check("abort_pe_finish", $countones(pe_finish), 0);
    check("abort_ofm_valid", ofm_valid, 0);
    tick();
    reset = 0;
    repeat (30) tick();
    check("abort_no_done", n_done, 0);
    check("abort_stays_idle", busy, 0);
    run("after_abort", 27, 0);

    // Random tap gaps, random downstream backpressure, random array latency and stray pe_valid.
    rand_mode = 1; ofm_mode = 2;
    run("random1", -1, 0);
    run("random2", -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
